wb_rr_writeback: RTL and testbench
==================================

# wb_rr_writeback

Parametrised writeback arbiter. It collects results from all execution units, grouped into NUM_WB_GROUPS writeback groups, and grants one unit per group per cycle to drive that group's register-file write port. It generalises the fixed-priority writeback stage with three additions: round-robin fairness via a rotating per-group priority pointer, a selectable snoop group, and a parametrised snoop delay for load/store forwarding.

## Interface
Parameters:
- CONFIG, EXAMPLE_CONFIG: cpu_config_t; supplies NUM_WB_GROUPS.
- NUM_UNITS, '{1, 4}: units per group; index i is group i.
- NUM_WB_UNITS, 5: total units; must equal the sum of NUM_UNITS.
- SNOOP_GROUP, 1: group mirrored onto wb_snoop; must be less than NUM_WB_GROUPS.
- SNOOP_DELAY, 1: register stages on the snoop path; range 1..3.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset; synchronous, active-high.
- unit_wb, unit_writeback_interface.wb, NUM_WB_UNITS array: per-unit id, done, rd inputs and ack output. Units are packed by group in ascending order.
- wb_packet, output, wb_packet_t [NUM_WB_GROUPS]: per-group valid, id, data.
- wb_snoop, output, wb_packet_t: SNOOP_GROUP packet delayed by SNOOP_DELAY cycles.

## Operation
- Global unit index = (cumulative count of units in lower groups) + local index j.
- Per group i: req = done vector, NUM_UNITS[i] bits wide.
- The arbiter picks the first requesting unit at or above ptr[i], wrapping past NUM_UNITS[i]-1 back to 0.
- wb_packet[i].valid = |req.
- wb_packet[i].id and wb_packet[i].data come from the selected unit.
- Exactly the selected unit gets ack = 1. All other acks are 0.
- If no unit is requesting: ack is all zero and the id/data values are don't-care.
- Pointer update on a valid grant: ptr[i] <= (sel + 1) mod NUM_UNITS[i]. With no grant, ptr[i] holds.
- If NUM_UNITS[i] == 1: no pointer register; sel = 0; valid = done; ack = done.
- Pointer width is max(1, $clog2(NUM_UNITS[i])). When sel = NUM_UNITS[i]-1 the pointer wraps to 0, including for non-power-of-2 unit counts.
- Snoop path: a SNOOP_DELAY-deep shift register of wb_packet[SNOOP_GROUP].
  - valid bits are reset.
  - id and data registers are not reset.

## Timing
- Grant is combinational: done is seen and ack is returned in the same cycle. wb_packet has 0-cycle latency.
- A unit holds done, id and rd stable until it sees ack.
- ptr changes one cycle after a grant, so a unit that is granted loses priority starting the next cycle.
- If a unit keeps done high and other units are also requesting, the other units are granted within NUM_UNITS[i]-1 cycles (no starvation).
- wb_snoop appears exactly SNOOP_DELAY cycles after the matching wb_packet[SNOOP_GROUP] cycle.
- Reset values:
  - every ptr = 0;
  - every wb_snoop valid stage = 0;
  - wb_packet and ack stay combinational and unaffected by rst.
- Reset asserted mid-stream:
  - in the following cycle the pointers are 0, so the lowest index wins;
  - the snoop valid stages are flushed, so no stale snoop appears after reset.
- A unit asserting done in the same cycle as a grant to another unit is only considered next cycle if it is not selected now. The done/ack handshake needs no extra cycle.

## Configuration
- WB_ROUND_ROBIN_EN defined: rotating-pointer arbitration as described above.
- WB_ROUND_ROBIN_EN undefined: fixed priority, lowest local index wins. No pointer registers are built and ptr is treated as constant 0. Snoop behaviour is unchanged.

## Structure
- Into cva5_types:
  - wb_packet_t (already present);
  - unit_count_t typedef;
  - the cumulative-unit-count function, promoted to the package so issue/decode can share the unit-to-group mapping.
- Sub-module wb_rr_arbiter:
  - parameters WIDTH and ROUND_ROBIN;
  - ports clk, rst, req[WIDTH], grant_valid, sel[$clog2 width];
  - one instance per group.
- The top level does the interface unpacking, the data/id muxing and the snoop shift register.

## Test plan
- Single unit, group 0 (NUM_UNITS = 1): done = 1, id = 3, rd = 32'hA5 → wb_packet[0] = {1, 3, 32'hA5} and ack = 1 in the same cycle.
- Group 1, units 0–3 all holding done with RR enabled:
  - grants over four cycles are 0, 1, 2, 3, then 0;
  - each ack is one cycle wide.
- Group 1 with NUM_UNITS = 3 (non-power-of-2), units 1 and 2 requesting:
  - grants alternate 1, 2, 1;
  - the pointer wraps from 2 to 0, never to an illegal value 3.
- Macro undefined, units 1 and 3 holding done: unit 1 is granted every cycle while it holds done. Unit 3 is granted only after unit 1 drops done.
- SNOOP_DELAY = 2, packet {1, 7, 32'h1234} on SNOOP_GROUP at cycle t → wb_snoop = {1, 7, 32'h1234} at t+2 and valid = 0 at t+1.
- rst pulsed while ptr = 2 and snoop valid stages are set:
  - next cycle ptr = 0;
  - wb_snoop.valid = 0 for SNOOP_DELAY cycles;
  - with all units requesting, the first grant after reset goes to unit 0.

Source files
------------

// File: rtl/wb_rr_writeback_pkg.sv
// Shared types for the writeback stage: packet format, CPU config and the
// unit-to-group mapping used by writeback, issue and decode.
package wb_rr_writeback_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned ID_W          = 4;
  localparam int unsigned MAX_WB_GROUPS = 4;
  localparam int unsigned UNIT_COUNT_W  = 8;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic            valid;
    id_t             id;
    logic [XLEN-1:0] data;
  } wb_packet_t;

  typedef struct packed {
    int unsigned NUM_WB_GROUPS;
  } cpu_config_t;

  localparam cpu_config_t EXAMPLE_CONFIG = '{NUM_WB_GROUPS: 32'd2};

  typedef logic [UNIT_COUNT_W-1:0] unit_count_t;
  typedef unit_count_t [0:MAX_WB_GROUPS-1] unit_count_vec_t;

  // Global index of the first unit of a group: sum of all lower group sizes.
  function automatic int unsigned unit_base(input unit_count_vec_t counts,
                                            input int unsigned group);
    int unsigned base;
    base = 0;
    for (int unsigned g = 0; g < MAX_WB_GROUPS; g++) begin
      if (g < group) base += 32'(counts[g]);
    end
    return base;
  endfunction

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/wb_rr_writeback_if.sv
// Execution-unit side of the writeback handshake: done/id/rd in, ack out.
interface wb_rr_writeback_if
  import wb_rr_writeback_pkg::*;
#(
  parameter int unsigned NUM_WB_UNITS = 5
);

  logic [NUM_WB_UNITS-1:0] done;
  logic [NUM_WB_UNITS-1:0] ack;
  id_t                     id [NUM_WB_UNITS];
  logic [XLEN-1:0]         rd [NUM_WB_UNITS];

  modport master (output done, output id, output rd, input ack);
  modport slave  (input done, input id, input rd, output ack);

endinterface

// File: rtl/wb_rr_writeback_arbiter.sv
// Per-group grant logic: round-robin from a rotating pointer, or fixed
// lowest-index priority when ROUND_ROBIN is 0 (no pointer register built).
module wb_rr_writeback_arbiter
  import wb_rr_writeback_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter bit          ROUND_ROBIN = 1'b1,
  localparam int unsigned SEL_W      = sel_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_i,
  output logic             grant_valid_o,
  output logic [SEL_W-1:0] sel_o
);

  logic [SEL_W-1:0] ptr;
  logic             upper_hit;
  logic [SEL_W-1:0] upper_sel;
  logic [SEL_W-1:0] any_sel;

  if (ROUND_ROBIN && (WIDTH > 1)) begin : g_rr
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
    end

    // Granted unit drops to lowest priority; explicit wrap for non-pow2 widths.
    always_comb begin
      ptr_d = ptr_q;
      if (grant_valid_o) begin
        ptr_d = (sel_o == SEL_W'(WIDTH - 1)) ? '0 : sel_o + SEL_W'(1);
      end
    end

    assign ptr = ptr_q;
  end else begin : g_fixed
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign ptr = '0;
  end

  // Lowest requester at/above ptr wins; otherwise wrap to lowest requester.
  always_comb begin
    upper_hit = 1'b0;
    upper_sel = '0;
    any_sel   = '0;
    for (int j = int'(WIDTH) - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        any_sel = SEL_W'(j);
        if (SEL_W'(j) >= ptr) begin
          upper_hit = 1'b1;
          upper_sel = SEL_W'(j);
        end
      end
    end
    grant_valid_o = |req_i;
    sel_o         = upper_hit ? upper_sel : any_sel;
  end

endmodule

// File: rtl/wb_rr_writeback.sv
// Writeback arbiter: one grant per group per cycle plus a delayed snoop copy
// of one group. WB_ROUND_ROBIN_EN selects rotating-pointer arbitration.
module wb_rr_writeback
  import wb_rr_writeback_pkg::*;
#(
  parameter cpu_config_t     CONFIG       = EXAMPLE_CONFIG,
  parameter unit_count_vec_t NUM_UNITS    = '{8'd1, 8'd4, 8'd0, 8'd0},
  parameter int unsigned     NUM_WB_UNITS = 5,
  parameter int unsigned     SNOOP_GROUP  = 1,
  parameter int unsigned     SNOOP_DELAY  = 1,
  localparam int unsigned    NUM_WB_GROUPS = CONFIG.NUM_WB_GROUPS
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_rr_writeback_if.slave       unit_wb,
  output wb_packet_t             wb_packet_o [NUM_WB_GROUPS],
  output wb_packet_t             wb_snoop_o
);

`ifdef WB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  logic [NUM_WB_UNITS-1:0] ack_all;

  for (genvar g = 0; g < NUM_WB_GROUPS; g++) begin : g_group
    localparam int unsigned N    = 32'(NUM_UNITS[g]);
    localparam int unsigned BASE = unit_base(NUM_UNITS, g);
    localparam int unsigned SW   = sel_width(N);

    logic [N-1:0]  req;
    logic [N-1:0]  ack_grp;
    logic          grant_valid;
    logic [SW-1:0] sel;
    wb_packet_t    pkt;

    assign req = unit_wb.done[BASE +: N];

    wb_rr_writeback_arbiter #(
      .WIDTH       (N),
      .ROUND_ROBIN (ROUND_ROBIN)
    ) u_arb (
      .clk           (clk),
      .rst           (rst),
      .req_i         (req),
      .grant_valid_o (grant_valid),
      .sel_o         (sel)
    );

    // Route the selected unit's id/data onto the port and ack only that unit.
    always_comb begin
      pkt       = '0;
      ack_grp   = '0;
      pkt.valid = grant_valid;
      for (int j = 0; j < int'(N); j++) begin
        if (SW'(j) == sel) begin
          pkt.id      = unit_wb.id[BASE + 32'(j)];
          pkt.data    = unit_wb.rd[BASE + 32'(j)];
          ack_grp[j]  = grant_valid;
        end
      end
    end

    assign wb_packet_o[g]      = pkt;
    assign ack_all[BASE +: N]  = ack_grp;
  end

  assign unit_wb.ack = ack_all;

  logic            snoop_valid_q [SNOOP_DELAY];
  id_t             snoop_id_q    [SNOOP_DELAY];
  logic [XLEN-1:0] snoop_data_q  [SNOOP_DELAY];

  // Valid stages flush on reset so no stale forward survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SNOOP_DELAY); s++) snoop_valid_q[s] <= 1'b0;
    end else begin
      snoop_valid_q[0] <= wb_packet_o[SNOOP_GROUP].valid;
      for (int s = 1; s < int'(SNOOP_DELAY); s++) snoop_valid_q[s] <= snoop_valid_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    snoop_id_q[0]   <= wb_packet_o[SNOOP_GROUP].id;
    snoop_data_q[0] <= wb_packet_o[SNOOP_GROUP].data;
    for (int s = 1; s < int'(SNOOP_DELAY); s++) begin
      snoop_id_q[s]   <= snoop_id_q[s-1];
      snoop_data_q[s] <= snoop_data_q[s-1];
    end
  end

  assign wb_snoop_o = '{valid: snoop_valid_q[SNOOP_DELAY-1],
                        id:    snoop_id_q[SNOOP_DELAY-1],
                        data:  snoop_data_q[SNOOP_DELAY-1]};

endmodule

// File: tb/tb_wb_rr_writeback.sv
// Bench for wb_rr_writeback: a 1+4 unit build (snoop delay 2) and a 1+3 unit
// build (snoop delay 1) checked against a scoreboard; honours WB_ROUND_ROBIN_EN.
module tb_wb_rr_writeback;
  import wb_rr_writeback_pkg::*;

`ifdef WB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam unit_count_vec_t UC4 = '{8'd1, 8'd4, 8'd0, 8'd0};
  localparam unit_count_vec_t UC3 = '{8'd1, 8'd3, 8'd0, 8'd0};
  localparam int N1  [2] = '{4, 3};
  localparam int DLY [2] = '{2, 1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_rr_writeback_if #(.NUM_WB_UNITS(5)) if4 ();
  wb_rr_writeback_if #(.NUM_WB_UNITS(4)) if3 ();
  wb_packet_t pkt4 [2];
  wb_packet_t pkt3 [2];
  wb_packet_t snoop4;
  wb_packet_t snoop3;

  wb_rr_writeback #(
    .CONFIG(EXAMPLE_CONFIG), .NUM_UNITS(UC4), .NUM_WB_UNITS(5),
    .SNOOP_GROUP(1), .SNOOP_DELAY(2)
  ) u_dut4 (
    .clk(clk), .rst(rst), .unit_wb(if4.slave), .wb_packet_o(pkt4), .wb_snoop_o(snoop4)
  );

  wb_rr_writeback #(
    .CONFIG(EXAMPLE_CONFIG), .NUM_UNITS(UC3), .NUM_WB_UNITS(4),
    .SNOOP_GROUP(1), .SNOOP_DELAY(1)
  ) u_dut3 (
    .clk(clk), .rst(rst), .unit_wb(if3.slave), .wb_packet_o(pkt3), .wb_snoop_o(snoop3)
  );

  typedef struct {
    wb_packet_t p0;
    wb_packet_t p1;
    wb_packet_t sn;
    logic [4:0] ack;
  } exp_t;

  exp_t       sb_q [$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [4:0] done_v [2];
  id_t        ids [2][5];
  logic [31:0] rds [2][5];
  int         ptr_m [2];
  wb_packet_t snoop_m [2][3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference grant: scan upward from the pointer modulo the group size.
  function automatic int pick(input logic [3:0] req, input int n, input int p);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = (p + k) % n;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic exp_t expect_for(input int k);
    exp_t e;
    int   g;
    e.ack = '0;
    e.p0 = '{valid: done_v[k][0], id: ids[k][0], data: rds[k][0]};
    e.ack[0] = done_v[k][0];
    g = pick(done_v[k][4:1], N1[k], ptr_m[k]);
    e.p1 = '{valid: (g >= 0), id: '0, data: '0};
    if (g >= 0) begin
      e.p1.id = ids[k][1+g];
      e.p1.data = rds[k][1+g];
      e.ack[1+g] = 1'b1;
    end
    e.sn = snoop_m[k][DLY[k]-1];
    return e;
  endfunction

  task automatic cmp_pkt(input string tag, input wb_packet_t got, input wb_packet_t exp);
    check({tag, ".valid"}, 64'(got.valid), 64'(exp.valid));
    if (exp.valid) begin
      check({tag, ".id"}, 64'(got.id), 64'(exp.id));
      check({tag, ".data"}, 64'(got.data), 64'(exp.data));
    end
  endtask

  task automatic compare(input int k, input wb_packet_t g0, input wb_packet_t g1,
                         input wb_packet_t sn, input logic [4:0] ack, input bit en);
    exp_t  e;
    string pfx;
    e = sb_q.pop_front();
    if (!en) return;
    pfx = $sformatf("c%0d dut%0d", cyc, (k == 0) ? 4 : 3);
    cmp_pkt({pfx, " wb0"}, g0, e.p0);
    cmp_pkt({pfx, " wb1"}, g1, e.p1);
    check({pfx, " ack"}, 64'(ack), 64'(e.ack));
    cmp_pkt({pfx, " snoop"}, sn, e.sn);
  endtask

  task automatic cycle(input logic r, input logic [4:0] d4, input logic [3:0] d3, input bit chk_en);
    int   g [2];
    exp_t e;
    @(negedge clk);
    rst = r;
    done_v[0] = d4;
    done_v[1] = {1'b0, d3};
    for (int k = 0; k < 2; k++)
      for (int u = 0; u < 5; u++) rds[k][u] = $urandom;
    rds[0][0] = 32'hA5;
    rds[0][4] = 32'h1234;
    if4.done = done_v[0];
    if3.done = done_v[1][3:0];
    for (int u = 0; u < 5; u++) begin
      if4.id[u] = ids[0][u];
      if4.rd[u] = rds[0][u];
    end
    for (int u = 0; u < 4; u++) begin
      if3.id[u] = ids[1][u];
      if3.rd[u] = rds[1][u];
    end
    for (int k = 0; k < 2; k++) begin
      g[k] = pick(done_v[k][4:1], N1[k], ptr_m[k]);
      sb_q.push_back(expect_for(k));
    end
    #1;
    compare(0, pkt4[0], pkt4[1], snoop4, if4.ack, chk_en);
    compare(1, pkt3[0], pkt3[1], snoop3, {1'b0, if3.ack}, chk_en);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      e = expect_for(k);
      if (r) ptr_m[k] = 0;
      else if (RR && g[k] >= 0) ptr_m[k] = (g[k] + 1) % N1[k];
      snoop_m[k][2] = snoop_m[k][1];
      snoop_m[k][1] = snoop_m[k][0];
      snoop_m[k][0] = e.p1;
      if (r) for (int s = 0; s < 3; s++) snoop_m[k][s].valid = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    ids[0] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    ids[1] = '{4'd2, 4'd8, 4'd9, 4'd10, 4'd0};
    for (int k = 0; k < 2; k++) begin
      ptr_m[k] = 0;
      for (int s = 0; s < 3; s++) snoop_m[k][s] = '0;
    end
    cycle(1'b1, 5'b00000, 4'b0000, 1'b0);
    cycle(1'b1, 5'b00000, 4'b0000, 1'b0);

    // Single-unit group: same-cycle packet and ack
    cycle(1'b0, 5'b00001, 4'b0001, 1'b1);
    // All of group 1 holding done
    repeat (5) cycle(1'b0, 5'b11110, 4'b1110, 1'b1);
    // Non-power-of-2 group, local units 1 and 2 requesting
    repeat (4) cycle(1'b0, 5'b11110, 4'b1100, 1'b1);
    // Snoop delay: lone id-7 packet between idle cycles
    cycle(1'b0, 5'b00000, 4'b0000, 1'b1);
    cycle(1'b0, 5'b10000, 4'b0000, 1'b1);
    cycle(1'b0, 5'b00000, 4'b0000, 1'b1);
    cycle(1'b0, 5'b00000, 4'b0000, 1'b1);
    // Local units 1 and 3 holding, then unit 1 drops
    repeat (3) cycle(1'b0, 5'b10100, 4'b1010, 1'b1);
    cycle(1'b0, 5'b10000, 4'b1000, 1'b1);
    // Move pointer to 2, fill snoop, then reset mid-stream with all requesting
    cycle(1'b0, 5'b00001, 4'b0000, 1'b1);
    cycle(1'b0, 5'b00100, 4'b0100, 1'b1);
    cycle(1'b0, 5'b11111, 4'b1111, 1'b1);
    cycle(1'b1, 5'b11111, 4'b1111, 1'b1);
    repeat (4) cycle(1'b0, 5'b11111, 4'b1111, 1'b1);
    // Random traffic with occasional resets
    repeat (80) cycle(logic'($urandom_range(0, 19) == 0), 5'($urandom), 4'($urandom), 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
